// File: rtl/ureg_pkg.sv
// rtl/ureg_pkg.sv - opcode constants shared by the register bank and its bit slices
package ureg_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD   = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'b001;
  localparam logic [OP_W-1:0] OP_CLEAR  = 3'b010;
  localparam logic [OP_W-1:0] OP_TOGGLE = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL    = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR    = 3'b101;
  localparam logic [OP_W-1:0] OP_ROL    = 3'b110;
  localparam logic [OP_W-1:0] OP_ROR    = 3'b111;

endpackage

// File: rtl/ureg_bit_slice.sv
// rtl/ureg_bit_slice.sv - next-state function for one storage bit
module ureg_bit_slice
  import ureg_pkg::*;
(
  input  logic            i_q,
  input  logic            i_left,
  input  logic            i_right,
  input  logic            i_d,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_en,
  output logic            o_next
);

  // Left neighbour is the next-higher bit, right neighbour the next-lower bit.
  always_comb begin
    o_next = i_q;
    if (i_en) begin
      case (i_op)
        OP_HOLD:   o_next = i_q;
        OP_LOAD:   o_next = i_d;
        OP_CLEAR:  o_next = 1'b0;
        OP_TOGGLE: o_next = i_q ^ i_d;
        OP_SHL:    o_next = i_right;
        OP_ROL:    o_next = i_right;
        OP_SHR:    o_next = i_left;
        OP_ROR:    o_next = i_left;
        default:   o_next = i_q;
      endcase
    end
  end

endmodule

// File: rtl/param_ureg_bank.sv
// rtl/param_ureg_bank.sv - WIDTH-bit opcode-driven register with serial I/O and change flag
module param_ureg_bank
  import ureg_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'd0
)
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [OP_W-1:0]  Op,
  input  logic [WIDTH-1:0] D,
  input  logic             SerIn,
  output logic [WIDTH-1:0] Q,
  output logic             SerOut,
  output logic             Changed
);

  logic [WIDTH-1:0] r_q;
  logic             r_serout;
  logic             r_changed;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  logic             w_right_end;
  logic             w_left_end;
  logic             w_shift_op;
  logic             w_shift_right;

  // Chain ends: rotates feed back the opposite end bit, shifts take SerIn.
  assign w_right_end = (Op == OP_ROL) ? r_q[WIDTH-1] : SerIn;
  assign w_left_end  = (Op == OP_ROR) ? r_q[0]       : SerIn;

  assign w_right = {r_q[WIDTH-2:0], w_right_end};
  assign w_left  = {w_left_end, r_q[WIDTH-1:1]};

  assign w_shift_op    = Op[2];
  assign w_shift_right = Op[0];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
    ureg_bit_slice u_slice (
      .i_q     (r_q[gi]),
      .i_left  (w_left[gi]),
      .i_right (w_right[gi]),
      .i_d     (D[gi]),
      .i_op    (Op),
      .i_en    (En),
      .o_next  (w_next[gi])
    );
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_q       <= RESET_VAL[WIDTH-1:0];
      r_serout  <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_q       <= w_next;
      r_changed <= (w_next != r_q);
      if (En && w_shift_op) begin
        r_serout <= w_shift_right ? r_q[0] : r_q[WIDTH-1];
      end
    end
  end

  assign Q       = r_q;
  assign SerOut  = r_serout;
  assign Changed = r_changed;

endmodule
